// File: rtl/sync_debounce_multi.sv
// sync_debounce_multi
//   Multi-channel input conditioner: each bit of dat_in is passed through a
//   STAGES-deep synchronizer, optionally debounced against a tick qualifier,
//   and the resulting level is edge-detected into one-cycle rise/fall pulses.
//
// Configuration macro: SYNC_DEBOUNCE_FILTER_EN
//   defined   : per-channel debounce counters are built; a level change is
//               accepted only after DEBOUNCE_CYCLES consecutive tick edges
//               at which the synchronized input differs from dat_out.
//   undefined : no counters, tick is ignored, dat_out follows the
//               synchronizer output one edge later.
//
// Parameters
//   WIDTH            number of independent channels
//   STAGES           synchronizer depth (2..8)
//   DEBOUNCE_CYCLES  qualifying ticks before a change is accepted (1..65535)
//   INIT_VALUE       reset value of synchronizer stages and dat_out
//
// Ports
//   clk         single clock
//   srst        synchronous active-high reset, overrides tick and dat_in
//   tick        debounce qualifier, counters advance only when high
//   dat_in      asynchronous raw inputs
//   dat_out     synchronized, debounced levels
//   rise        one-cycle pulse per channel on a dat_out 0->1 change
//   fall        one-cycle pulse per channel on a dat_out 1->0 change
//   any_change  OR of all rise/fall bits, aligned with them
module sync_debounce_multi #(
  parameter int               WIDTH           = 8,
  parameter int               STAGES          = 3,
  parameter int               DEBOUNCE_CYCLES = 4,
  parameter logic [WIDTH-1:0] INIT_VALUE      = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             tick,
  input  logic [WIDTH-1:0] dat_in,
  output logic [WIDTH-1:0] dat_out,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             any_change
);

  // Stage p0: synchronizer chain, plain flops with nothing in between so
  // the tools keep the metastability chain intact.
  (* preserve *) logic [WIDTH-1:0] sync_p0 [STAGES];
  logic [WIDTH-1:0] s_p0;

  always_ff @(posedge clk) begin
    if (srst) begin
      for (int k = 0; k < STAGES; k++) begin
        sync_p0[k] <= INIT_VALUE;
      end
    end else begin
      sync_p0[0] <= dat_in;
      for (int k = 1; k < STAGES; k++) begin
        sync_p0[k] <= sync_p0[k-1];
      end
    end
  end

  assign s_p0 = sync_p0[STAGES-1];

  // Stage p1: debounced level and edge pulses.
  logic [WIDTH-1:0] out_p1;
  logic [WIDTH-1:0] out_nxt;
  logic [WIDTH-1:0] rise_p1;
  logic [WIDTH-1:0] fall_p1;
  logic             any_p1;

`ifdef SYNC_DEBOUNCE_FILTER_EN
  localparam int               CNT_W   = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] cnt_p1  [WIDTH];
  logic [CNT_W-1:0] cnt_nxt [WIDTH];

  // Saturating increment: the count is cleared on acceptance, so the clamp
  // only guarantees the counter can never wrap back to a small value.
  function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
    return (c >= CNT_MAX) ? CNT_MAX : c + CNT_W'(1);
  endfunction

  // Any edge where the synchronized level agrees with dat_out clears the
  // count, so a change is only accepted after an unbroken run of
  // DEBOUNCE_CYCLES disagreeing tick edges.
  always_comb begin
    out_nxt = out_p1;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_nxt[i] = cnt_p1[i];
      if (s_p0[i] == out_p1[i]) begin
        cnt_nxt[i] = '0;
      end else if (!tick) begin
        cnt_nxt[i] = cnt_p1[i];
      end else if (cnt_p1[i] == CNT_MAX) begin
        out_nxt[i] = s_p0[i];
        cnt_nxt[i] = '0;
      end else begin
        cnt_nxt[i] = cnt_inc(cnt_p1[i]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      for (int i = 0; i < WIDTH; i++) begin
        cnt_p1[i] <= '0;
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        cnt_p1[i] <= cnt_nxt[i];
      end
    end
  end
`else
  // Without the filter the qualifier has no effect.
  logic unused_tick;
  assign unused_tick = tick;
  assign out_nxt     = s_p0;
`endif

  // Pulses are registered on the same edge that updates dat_out, so they
  // line up with the cycle in which the new level is first visible.
  always_ff @(posedge clk) begin
    if (srst) begin
      out_p1  <= INIT_VALUE;
      rise_p1 <= '0;
      fall_p1 <= '0;
      any_p1  <= 1'b0;
    end else begin
      out_p1  <= out_nxt;
      rise_p1 <= out_nxt & ~out_p1;
      fall_p1 <= ~out_nxt & out_p1;
      any_p1  <= |(out_nxt ^ out_p1);
    end
  end

  assign dat_out    = out_p1;
  assign rise       = rise_p1;
  assign fall       = fall_p1;
  assign any_change = any_p1;

endmodule

// File: tb/tb_sync_debounce_multi.sv
// Bench for sync_debounce_multi. Stimulus pushes the expected pulse events
// (cycle, dat_out, rise, fall) into a queue; a monitor pops one entry each
// time any_change is seen and flags missing, early, late or stray pulses.
module tb_sync_debounce_multi;

`ifdef SYNC_DEBOUNCE_FILTER_EN
  localparam int ST  = 3;
  localparam int LAT = 7;   // STAGES + DEBOUNCE_CYCLES with tick held high
`else
  localparam int ST  = 2;
  localparam int LAT = 3;   // STAGES + 1
`endif

  logic       clk = 1'b0;
  logic       srst;
  logic       tick;
  logic [7:0] dat_in;
  logic [7:0] dat_out;
  logic [7:0] rise;
  logic [7:0] fall;
  logic       any_change;

  sync_debounce_multi #(
    .WIDTH          (8),
    .STAGES         (ST),
    .DEBOUNCE_CYCLES(4),
    .INIT_VALUE     (8'h00)
  ) dut (
    .clk       (clk),
    .srst      (srst),
    .tick      (tick),
    .dat_in    (dat_in),
    .dat_out   (dat_out),
    .rise      (rise),
    .fall      (fall),
    .any_change(any_change)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [7:0] dout;
    logic [7:0] r;
    logic [7:0] f;
  } exp_t;

  exp_t exp_q[$];
  int   cyc       = 0;
  int   n_cmp     = 0;
  int   n_bad     = 0;
  int   tick_mode = 0;   // 0: always 1, 1: every 4th edge, 2: always 0
  bit   mon_en    = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Advance n clock edges; inputs change 1 time unit after each edge.
  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      case (tick_mode)
        0:       tick = 1'b1;
        1:       tick = ((cyc + 1) % 4 == 0);
        default: tick = 1'b0;
      endcase
    end
  endtask

  task automatic push(input int at, input logic [7:0] d, input logic [7:0] r,
                      input logic [7:0] f);
    exp_t e;
    e.cyc  = at;
    e.dout = d;
    e.r    = r;
    e.f    = f;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [7:0] got,
                     input logic [7:0] req);
    n_cmp++;
    if (got !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", name, got, req);
    end
  endtask

  // Monitor: sampled on the falling edge, half a cycle after outputs move.
  always @(negedge clk) begin
    if (mon_en) begin
      if (any_change === 1'b1) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_pulse: cyc=%0d dat_out=%h rise=%h fall=%h, required no pulse",
                   cyc, dat_out, rise, fall);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (e.cyc != cyc || dat_out !== e.dout || rise !== e.r || fall !== e.f) begin
            n_bad++;
            $display("FAIL pulse_evt: got cyc=%0d dat_out=%h rise=%h fall=%h, required cyc=%0d dat_out=%h rise=%h fall=%h",
                     cyc, dat_out, rise, fall, e.cyc, e.dout, e.r, e.f);
          end
        end
      end else begin
        n_cmp++;
        if ((rise | fall) !== 8'h00) begin
          n_bad++;
          $display("FAIL stray_edge: cyc=%0d rise=%h fall=%h with any_change=%b, required rise=00 fall=00",
                   cyc, rise, fall, any_change);
        end
        if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
          exp_t e;
          e = exp_q.pop_front();
          n_cmp++;
          n_bad++;
          $display("FAIL missed_pulse: no any_change by cyc=%0d, required at cyc=%0d dat_out=%h rise=%h fall=%h",
                   cyc, e.cyc, e.dout, e.r, e.f);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    srst      = 1'b1;
    dat_in    = 8'h00;
    tick      = 1'b1;
    tick_mode = 0;
    step(3);
    @(negedge clk);
    chk("rst_dat_out", dat_out, 8'h00);
    chk("rst_rise", rise, 8'h00);
    chk("rst_fall", fall, 8'h00);
    chk("rst_any", {7'b0, any_change}, 8'h00);
    mon_en = 1'b1;
    step(1);
    srst = 1'b0;
    step(4);
    @(negedge clk);
    chk("post_release_dat_out", dat_out, 8'h00);

`ifdef SYNC_DEBOUNCE_FILTER_EN
    // Stable 0->1 on channel 0: accepted exactly 7 edges later.
    step(1);
    dat_in = 8'h01;
    push(cyc + LAT, 8'h01, 8'h01, 8'h00);
    step(LAT - 1);
    @(negedge clk);
    chk("ch0_before_latency", dat_out, 8'h00);
    step(10);
    @(negedge clk);
    chk("ch0_settled", dat_out, 8'h01);

    // 3-cycle pulse on channel 2 is rejected.
    step(1);
    dat_in = 8'h05;
    step(3);
    dat_in = 8'h01;
    step(12);
    @(negedge clk);
    chk("glitch3_ch2", dat_out, 8'h01);

    // 4-cycle pulse on channel 3 is just long enough: rises at +7, falls at +11.
    step(1);
    dat_in = 8'h09;
    push(cyc + 7, 8'h09, 8'h08, 8'h00);
    push(cyc + 11, 8'h01, 8'h00, 8'h08);
    step(4);
    dat_in = 8'h01;
    step(12);
    @(negedge clk);
    chk("pulse4_ch3_settled", dat_out, 8'h01);

    // Tick every 4th edge: s arrives at +3, tick edges at +4,+8,+12,+16.
    tick_mode = 1;
    step(1);
    for (int k = 0; k < 4 && (cyc % 4) != 0; k++) step(1);
    dat_in = 8'h03;
    push(cyc + 16, 8'h03, 8'h02, 8'h00);
    step(15);
    @(negedge clk);
    chk("slow_tick_before", dat_out, 8'h01);
    step(4);
    tick_mode = 0;
    step(2);

    // All channels high, then all drop together.
    step(1);
    dat_in = 8'hFF;
    push(cyc + LAT, 8'hFF, 8'hFC, 8'h00);
    step(12);
    @(negedge clk);
    chk("all_high", dat_out, 8'hFF);
    step(1);
    dat_in = 8'h00;
    push(cyc + LAT, 8'h00, 8'h00, 8'hFF);
    step(12);
    @(negedge clk);
    chk("all_low", dat_out, 8'h00);

    // Reset while channel 4 has counted to 2: the pending change is lost.
    step(1);
    dat_in = 8'h10;
    step(5);
    srst   = 1'b1;
    dat_in = 8'h00;
    step(2);
    @(negedge clk);
    chk("midcount_rst_dat_out", dat_out, 8'h00);
    chk("midcount_rst_any", {7'b0, any_change}, 8'h00);
    step(1);
    srst = 1'b0;
    step(12);
    @(negedge clk);
    chk("midcount_after_release", dat_out, 8'h00);
`else
    // Stable 0->1 on channel 5: visible after STAGES+1 = 3 edges.
    step(1);
    dat_in = 8'h20;
    push(cyc + LAT, 8'h20, 8'h20, 8'h00);
    step(LAT - 1);
    @(negedge clk);
    chk("ch5_before_latency", dat_out, 8'h00);
    step(6);
    @(negedge clk);
    chk("ch5_settled", dat_out, 8'h20);

    // 1-cycle glitch on channel 0 passes straight through: rise then fall.
    step(1);
    dat_in = 8'h21;
    push(cyc + 3, 8'h21, 8'h01, 8'h00);
    push(cyc + 4, 8'h20, 8'h00, 8'h01);
    step(1);
    dat_in = 8'h20;
    step(6);
    @(negedge clk);
    chk("glitch1_settled", dat_out, 8'h20);

    // tick held low has no effect on propagation.
    tick_mode = 2;
    step(1);
    dat_in = 8'h24;
    push(cyc + LAT, 8'h24, 8'h04, 8'h00);
    step(6);
    @(negedge clk);
    chk("tick_low_ch2", dat_out, 8'h24);
    tick_mode = 0;

    // All channels high, then all drop together.
    step(1);
    dat_in = 8'hFF;
    push(cyc + LAT, 8'hFF, 8'hDB, 8'h00);
    step(6);
    @(negedge clk);
    chk("all_high", dat_out, 8'hFF);
    step(1);
    dat_in = 8'h00;
    push(cyc + LAT, 8'h00, 8'h00, 8'hFF);
    step(6);
    @(negedge clk);
    chk("all_low", dat_out, 8'h00);

    // Reset while a change is inside the synchronizer.
    step(1);
    dat_in = 8'h10;
    step(1);
    srst   = 1'b1;
    dat_in = 8'h00;
    step(2);
    @(negedge clk);
    chk("midsync_rst_dat_out", dat_out, 8'h00);
    chk("midsync_rst_any", {7'b0, any_change}, 8'h00);
    step(1);
    srst = 1'b0;
    step(6);
    @(negedge clk);
    chk("midsync_after_release", dat_out, 8'h00);
`endif

    step(10);
    @(negedge clk);
    while (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_cmp++;
      n_bad++;
      $display("FAIL pending_pulse: never seen, required at cyc=%0d dat_out=%h rise=%h fall=%h",
               e.cyc, e.dout, e.r, e.f);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sync_debounce_multi.md
SYNC_DEBOUNCE_MULTI -- requirements
Module: sync_debounce_multi

Interface
REQ-001 Parameter WIDTH, default 8: number of independent input channels.
REQ-002 Parameter STAGES, default 3: synchronizer depth; legal range 2..8.
REQ-003 Parameter DEBOUNCE_CYCLES, default 4: qualifying ticks before an output change is accepted; legal range 1..65535.
REQ-004 Parameter INIT_VALUE, default {WIDTH{1'b0}}: reset value of every per-channel state bit.
REQ-005 Port clk, input, 1: single clock for all logic.
REQ-006 Port srst, input, 1: reset, synchronous, active-high.
REQ-007 Port tick, input, 1: debounce qualifier; the debounce counter advances only on cycles with tick=1.
REQ-008 Port dat_in, input, WIDTH: asynchronous raw inputs.
REQ-009 Port dat_out, output, WIDTH: synchronized, debounced levels.
REQ-010 Port rise, output, WIDTH: per-channel 1-cycle pulse on a dat_out 0->1 change.
REQ-011 Port fall, output, WIDTH: per-channel 1-cycle pulse on a dat_out 1->0 change.
REQ-012 Port any_change, output, 1: OR-reduction of rise|fall, registered in the same cycle as rise and fall.

Function
REQ-013 Each channel SHALL pass dat_in through a STAGES-deep flop chain clocked by clk; the last stage is s[i].
- The chain has no logic between stages.
- The chain carries the synthesis preserve attribute.
REQ-014 Each channel SHALL hold a counter of width clog2(DEBOUNCE_CYCLES)+1 and an output register out[i].
REQ-015 Per channel, per clock edge, the debounce update SHALL be:
- if s==out, then cnt<=0;
- else if tick=0, then hold cnt;
- else if cnt==DEBOUNCE_CYCLES-1, then out<=s and cnt<=0;
- else cnt<=cnt+1.
REQ-016 A single-edge mismatch between s and out (glitch shorter than DEBOUNCE_CYCLES ticks) SHALL clear cnt and SHALL NOT change out.
REQ-017 With tick held at 1, latency from a stable dat_in change to the dat_out change SHALL be exactly STAGES+DEBOUNCE_CYCLES clock edges.
REQ-018 With DEBOUNCE_CYCLES=1, out SHALL follow s on the first tick edge at which they differ.
REQ-019 rise[i] SHALL be 1 exactly in the cycle where out[i] has just become 1, and 0 otherwise; fall[i] is the same for 0.
REQ-020 Simultaneous changes on several channels SHALL produce simultaneous independent pulses, with any_change=1 for that single cycle.
REQ-021 Channels SHALL be fully independent: no shared counter and no cross-channel priority.
REQ-022 Counter arithmetic SHALL never wrap; cnt never exceeds DEBOUNCE_CYCLES-1.

Reset
REQ-023 While srst=1 at a clock edge:
- all synchronizer stages and out SHALL load INIT_VALUE;
- cnt SHALL load 0;
- rise, fall and any_change SHALL load 0.
REQ-024 srst SHALL take priority over tick and dat_in.
REQ-025 Reset asserted mid-count SHALL discard the pending change.
REQ-026 The first cycle after reset release SHALL produce no edge pulse, since the stages equal out.

Configuration
REQ-027 Macro SYNC_DEBOUNCE_FILTER_EN defined: the debounce counters per REQ-014 to REQ-018 SHALL be compiled in.
REQ-028 Macro SYNC_DEBOUNCE_FILTER_EN undefined:
- counters SHALL be omitted and tick ignored;
- out<=s every edge, giving latency STAGES+1 edges;
- rise, fall and any_change still operate per REQ-019 and REQ-020.

Verification
REQ-029 WIDTH=8, STAGES=3, DEBOUNCE_CYCLES=4, tick=1: dat_in[0] 0->1 held -> dat_out[0]=1 after exactly 7 edges, with rise[0] and any_change high for one cycle and fall=0.
REQ-030 Same configuration: dat_in[2] pulsed high for 3 cycles -> dat_out[2] stays 0 and no pulses occur.
REQ-031 tick=1 every 4th cycle, DEBOUNCE_CYCLES=4, dat_in[1] 0->1 held -> dat_out[1] rises only after 4 tick edges following the arrival of s, with no earlier change.
REQ-032 dat_in=8'hFF -> 8'h00 in one cycle with dat_out=8'hFF -> fall=8'hFF for exactly one cycle and any_change=1 for one cycle.
REQ-033 srst asserted when cnt=2 for a pending 0->1 change, then dat_in returned to 0 -> dat_out=INIT_VALUE and no pulse after release.
REQ-034 Build without SYNC_DEBOUNCE_FILTER_EN and STAGES=2: dat_in[5] 0->1 -> dat_out[5]=1 after 3 edges, and a 1-cycle glitch produces a rise followed by a fall.
